// File: rtl/rx_pkg.sv
// Shared constants and helpers for the serial word receiver.
package rx_pkg;

  localparam bit RX_MSB_FIRST = 1'b1;
  localparam bit RX_LSB_FIRST = 1'b0;

  localparam int unsigned PERR_W = 8;

  // Ceiling log2, usable in constant expressions; returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/rx_word_fifo.sv
// Show-ahead word FIFO: rdata always presents the head, and holds its last value when empty.
module rx_word_fifo
  import rx_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [clog2(DEPTH):0]  fill
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (count_q > CW'(1)) begin
        head_d = mem[rd_ptr_q + AW'(1)];
      end else if (do_push) begin
        head_d = wdata;
      end
    end else if (do_push && empty) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      head_q <= head_d;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign rdata = head_q;
  assign fill  = count_q;

endmodule

// File: rtl/serial_word_rx.sv
// Serial word receiver: samples datain every BIT_DIV clocks while comEn is high, assembles
// WIDTH-bit words (optional even parity) and queues them in a show-ahead FIFO.
module serial_word_rx
  import rx_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BIT_DIV   = 102,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = RX_MSB_FIRST,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   datain,
  input  logic                   comEn,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [clog2(DEPTH):0]  fill,
  output logic                   overflow,
  output logic [PERR_W-1:0]      perr_cnt,
  input  logic                   ovf_clr
);

  localparam int unsigned FRAME = WIDTH + PARITY_EN;
  localparam int unsigned DIV_W = clog2(BIT_DIV);
  localparam int unsigned CNT_W = clog2(FRAME);

  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  bitcnt_q;
  logic [FRAME-1:0]  shift_q;
  logic [FRAME-1:0]  frame_next;
  logic [WIDTH-1:0]  payload;
  logic              sample_tick;
  logic              last_bit;
  logic              par_ok;

  logic              done_q;
  logic              good_q;
  logic [WIDTH-1:0]  word_q;
  logic              overflow_q;
  logic [PERR_W-1:0] perr_q;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;

  assign sample_tick = comEn && (div_q == DIV_W'(BIT_DIV - 1));
  assign last_bit    = (bitcnt_q == CNT_W'(FRAME - 1));

  // The frame as it will look once the current bit is shifted in.
  assign frame_next = MSB_FIRST ? {shift_q[FRAME-2:0], datain}
                                : {datain, shift_q[FRAME-1:1]};

  // Parity, when present, trails the payload in the frame.
  assign payload = MSB_FIRST ? frame_next[FRAME-1 -: WIDTH] : frame_next[WIDTH-1:0];
  assign par_ok  = (PARITY_EN == 0) || !(^frame_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (!comEn || div_q == DIV_W'(BIT_DIV - 1)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else if (!comEn) begin
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else if (sample_tick) begin
      if (last_bit) begin
        bitcnt_q <= '0;
        shift_q  <= '0;
      end else begin
        bitcnt_q <= bitcnt_q + 1'b1;
        shift_q  <= frame_next;
      end
    end
  end

  // Completed frame is held one cycle before the push so the FIFO sees a registered word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      good_q <= 1'b0;
      word_q <= '0;
    end else begin
      done_q <= sample_tick & last_bit;
      if (sample_tick && last_bit) begin
        word_q <= payload;
        good_q <= par_ok;
      end
    end
  end

  assign push = done_q & good_q;
  assign pop  = rd_ready & ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      perr_q     <= '0;
    end else begin
      if (push && fifo_full && !pop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
      if (done_q && !good_q && perr_q != '1) begin
        perr_q <= perr_q + 1'b1;
      end
    end
  end

  rx_word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (word_q),
    .pop   (rd_ready),
    .rdata (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .fill  (fill)
  );

  assign rd_valid = ~fifo_empty;
  assign overflow = overflow_q;
  assign perr_cnt = perr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed and randomized checks of serial_word_rx in three configurations, against a
// word-level queue model.
module tb_serial_word_rx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        din   [3];
  logic        comen [3];
  logic        rdy   [3];
  logic        oclr  [3];
  logic        vld   [3];
  logic [2:0]  fill  [3];
  logic        ovf   [3];
  logic [7:0]  perr  [3];
  logic [31:0] rdata_a;
  logic [7:0]  rdata_b;
  logic [7:0]  rdata_c;

  int n_checks = 0;
  int n_fail   = 0;

  // a: defaults; b: 8-bit LSB-first; c: 8-bit MSB-first with parity
  serial_word_rx u_a (
    .clk(clk), .reset(reset), .datain(din[0]), .comEn(comen[0]), .rd_data(rdata_a),
    .rd_valid(vld[0]), .rd_ready(rdy[0]), .fill(fill[0]), .overflow(ovf[0]),
    .perr_cnt(perr[0]), .ovf_clr(oclr[0])
  );

  serial_word_rx #(.WIDTH(8), .BIT_DIV(4), .DEPTH(4), .MSB_FIRST(1'b0), .PARITY_EN(0)) u_b (
    .clk(clk), .reset(reset), .datain(din[1]), .comEn(comen[1]), .rd_data(rdata_b),
    .rd_valid(vld[1]), .rd_ready(rdy[1]), .fill(fill[1]), .overflow(ovf[1]),
    .perr_cnt(perr[1]), .ovf_clr(oclr[1])
  );

  serial_word_rx #(.WIDTH(8), .BIT_DIV(4), .DEPTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1)) u_c (
    .clk(clk), .reset(reset), .datain(din[2]), .comEn(comen[2]), .rd_data(rdata_c),
    .rd_valid(vld[2]), .rd_ready(rdy[2]), .fill(fill[2]), .overflow(ovf[2]),
    .perr_cnt(perr[2]), .ovf_clr(oclr[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] head(input int d);
    if (d == 0) return rdata_a;
    if (d == 1) return {24'd0, rdata_b};
    return {24'd0, rdata_c};
  endfunction

  // Hold one bit for a full bit period; returns on the negedge after its sample edge.
  task automatic send_bit(input int d, input logic b);
    din[d]   = b;
    comen[d] = 1'b1;
    repeat ((d == 0) ? 102 : 4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [31:0] word, input int w, input bit msb,
                            input bit has_par, input logic par_bit);
    for (int i = 0; i < w; i++) begin
      send_bit(d, msb ? word[w-1-i] : word[i]);
    end
    if (has_par) send_bit(d, par_bit);
  endtask

  task automatic end_frame(input int d);
    comen[d] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop(input int d);
    rdy[d] = 1'b1;
    @(negedge clk);
    rdy[d] = 1'b0;
  endtask

  task automatic pulse_clr(input int d);
    oclr[d] = 1'b1;
    @(negedge clk);
    oclr[d] = 1'b0;
  endtask

  task automatic drain(input int d, input string tag, inout logic [31:0] q[$]);
    while (q.size() > 0) begin
      check({tag, " valid"}, 32'(vld[d]), 32'd1);
      check({tag, " data"}, head(d), q[0]);
      pop(d);
      void'(q.pop_front());
    end
    check({tag, " empty fill"}, 32'(fill[d]), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] w;
    logic [7:0]  pl;
    bit          bad;
    int          good_n;
    int          exp_perr;
    bit          exp_ovf;

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      din[d] = 1'b0; comen[d] = 1'b0; rdy[d] = 1'b0; oclr[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset valid %0d", d), 32'(vld[d]), 32'd0);
      check($sformatf("reset fill %0d", d), 32'(fill[d]), 32'd0);
      check($sformatf("reset ovf %0d", d), 32'(ovf[d]), 32'd0);
      check($sformatf("reset perr %0d", d), 32'(perr[d]), 32'd0);
      check($sformatf("reset data %0d", d), head(d), 32'd0);
    end

    // LSB-first assembly
    send_frame(1, 32'h01, 8, 1'b0, 1'b0, 1'b0);
    end_frame(1);
    check("lsb first data", head(1), 32'h01);
    check("lsb first fill", 32'(fill[1]), 32'd1);
    pop(1);

    // Random LSB-first burst overruns the 4-entry FIFO
    exp_ovf = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w = 32'($urandom_range(0, 255));
      if (q.size() < 4) q.push_back(w);
      else exp_ovf = 1'b1;
      send_frame(1, w, 8, 1'b0, 1'b0, 1'b0);
    end
    end_frame(1);
    check("b burst fill", 32'(fill[1]), 32'd4);
    check("b burst ovf", 32'(ovf[1]), 32'(exp_ovf));
    drain(1, "b burst", q);
    pulse_clr(1);
    check("b ovf clr", 32'(ovf[1]), 32'd0);

    // Parity: good frame is pushed, bad frame is counted and dropped
    send_frame(2, 32'h03, 8, 1'b1, 1'b1, 1'b0);
    end_frame(2);
    check("par good fill", 32'(fill[2]), 32'd1);
    check("par good data", head(2), 32'h03);
    check("par good perr", 32'(perr[2]), 32'd0);
    send_frame(2, 32'h03, 8, 1'b1, 1'b1, 1'b1);
    end_frame(2);
    check("par bad fill", 32'(fill[2]), 32'd1);
    check("par bad perr", 32'(perr[2]), 32'd1);
    pop(2);

    // Random payloads, some with corrupted parity
    exp_perr = 1;
    good_n   = 0;
    for (int i = 0; i < 8; i++) begin
      pl  = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 2) == 0);
      if (bad) exp_perr++;
      else begin
        good_n++;
        if (q.size() < 4) q.push_back(32'(pl));
      end
      send_frame(2, 32'(pl), 8, 1'b1, 1'b1, (^pl) ^ bad);
    end
    end_frame(2);
    check("c rand perr", 32'(perr[2]), 32'(exp_perr));
    check("c rand fill", 32'(fill[2]), 32'(q.size()));
    check("c rand ovf", 32'(ovf[2]), 32'(good_n > 4));
    drain(2, "c rand", q);

    // perr_cnt saturates
    for (int i = 0; i < 260; i++) begin
      send_frame(2, 32'h01, 8, 1'b1, 1'b1, 1'b0);
    end
    end_frame(2);
    check("perr saturate", 32'(perr[2]), 32'd255);
    check("perr sat fill", 32'(fill[2]), 32'd0);

    // Default config, single word and its output latency
    send_frame(0, 32'hA5A5_0F0F, 32, 1'b1, 1'b0, 1'b0);
    check("latency +1", 32'(vld[0]), 32'd0);
    comen[0] = 1'b0;
    @(negedge clk);
    check("latency +2", 32'(vld[0]), 32'd1);
    check("a word data", head(0), 32'hA5A5_0F0F);
    check("a word fill", 32'(fill[0]), 32'd1);
    pop(0);
    check("a popped fill", 32'(fill[0]), 32'd0);
    pop(0);
    check("empty pop fill", 32'(fill[0]), 32'd0);
    check("empty pop hold", head(0), 32'hA5A5_0F0F);

    // Five back-to-back words into a 4-deep FIFO
    exp_ovf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      if (q.size() < 4) q.push_back(w);
      else exp_ovf = 1'b1;
      send_frame(0, w, 32, 1'b1, 1'b0, 1'b0);
    end
    end_frame(0);
    check("a full fill", 32'(fill[0]), 32'd4);
    check("a full ovf", 32'(ovf[0]), 32'(exp_ovf));
    check("a full head", head(0), q[0]);
    pulse_clr(0);
    check("a ovf clr", 32'(ovf[0]), 32'd0);

    // Push into a full FIFO while popping
    w = $urandom;
    send_frame(0, w, 32, 1'b1, 1'b0, 1'b0);
    rdy[0]   = 1'b1;
    comen[0] = 1'b0;
    @(negedge clk);
    rdy[0] = 1'b0;
    void'(q.pop_front());
    q.push_back(w);
    @(negedge clk);
    check("push pop fill", 32'(fill[0]), 32'd4);
    check("push pop ovf", 32'(ovf[0]), 32'd0);
    check("push pop head", head(0), q[0]);
    drain(0, "a drain", q);

    // Aborted partial frame leaves no trace
    for (int i = 0; i < 17; i++) send_bit(0, 1'($urandom_range(0, 1)));
    comen[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort fill", 32'(fill[0]), 32'd0);
    w = $urandom;
    send_frame(0, w, 32, 1'b1, 1'b0, 1'b0);
    end_frame(0);
    check("after abort fill", 32'(fill[0]), 32'd1);
    check("after abort data", head(0), w);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    reset = 1'b1;
    #1;
    check("mid reset data", head(0), 32'd0);
    check("mid reset valid", 32'(vld[0]), 32'd0);
    check("mid reset fill", 32'(fill[0]), 32'd0);
    check("mid reset ovf", 32'(ovf[0]), 32'd0);
    check("mid reset perr", 32'(perr[0]), 32'd0);
    @(negedge clk);
    comen[0] = 1'b0;
    reset    = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
